// File: rtl/mips_fetch.sv
// Instruction fetch stage: streams one read per cycle into mips_memory and hands
// returned words, tagged with their PC, to decode through a one-entry skid buffer.
module mips_fetch #(
  parameter int unsigned MEMSIZE    = 1024,
  parameter logic [31:0] START_ADDR = 32'h8002_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] mem_addr,
  output logic        mem_enable,
  output logic        mem_rw,
  output logic [1:0]  mem_access_size,
  input  logic [31:0] mem_dout,
  input  logic        mem_busy,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  output logic        insn_valid,
  output logic        fetch_fault
);

  localparam logic [31:0] END_ADDR = START_ADDR + 32'(MEMSIZE) - 32'd4;

  logic [31:0] pc;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic        skid_valid;
  logic [31:0] skid_insn;
  logic [31:0] skid_pc;

  logic in_range;
  logic issue_ok;   // every issue condition except the window check
  logic issue;
  logic consume;
  logic out_free;

  always_comb begin
    in_range = (pc >= START_ADDR) && (pc <= END_ADDR);
    // Holding off issue while decode stalls a full output with a read in flight
    // is what guarantees every returned word lands in a free slot.
    issue_ok = !reset && !branch_taken && !fetch_fault && !mem_busy && !skid_valid
               && !(insn_valid && stall && inflight);
    issue    = issue_ok && in_range;
    consume  = insn_valid && !stall;
    out_free = !insn_valid || consume;
  end

  assign mem_addr        = pc;
  assign mem_enable      = issue;
  assign mem_rw          = 1'b0;
  assign mem_access_size = 2'b00;

  // NOTE: sequential state uses non-blocking assignments only, so every read of
  // pc/insn_valid/etc. in this block sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= START_ADDR;
      inflight    <= 1'b0;
      skid_valid  <= 1'b0;
      insn_valid  <= 1'b0;
      insn        <= 32'd0;
      insn_pc     <= 32'd0;
      fetch_fault <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) pc <= pc + 32'd4;
      if (issue_ok && !in_range) fetch_fault <= 1'b1;

      if (branch_taken) begin
        pc         <= {branch_target[31:2], 2'b00};
        skid_valid <= 1'b0;
        insn_valid <= 1'b0;
      end else if (out_free) begin
        if (skid_valid) begin
          insn       <= skid_insn;
          insn_pc    <= skid_pc;
          insn_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else if (inflight) begin
          insn       <= mem_dout;
          insn_pc    <= inflight_pc;
          insn_valid <= 1'b1;
        end else begin
          insn_valid <= 1'b0;
        end
      end else if (inflight) begin
        skid_valid <= 1'b1;
      end
    end
  end

  // NOTE: payload registers carry no reset; their valid flags above gate every use.
  always_ff @(posedge clk) begin
    if (issue) inflight_pc <= pc;
    if (!branch_taken && !out_free && inflight) begin
      skid_insn <= mem_dout;
      skid_pc   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_mips_fetch.sv
// Bench for mips_fetch: behavioural memory, directed scenarios, then random
// stall/busy/branch/reset traffic checked by an in-order address-stream scoreboard.
module tb_mips_fetch;

  localparam logic [31:0] START = 32'h8002_0000;
  localparam int unsigned MSIZE = 1024;
  localparam logic [31:0] LAST  = START + MSIZE - 4;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, mem_busy;
  logic [31:0] branch_target;
  logic [31:0] mem_addr, mem_dout, insn, insn_pc;
  logic        mem_enable, mem_rw, insn_valid, fetch_fault;
  logic [1:0]  mem_access_size;

  logic [31:0] mem [0:255];
  logic [31:0] exp_q[$];
  logic [31:0] sb_e;
  int tests = 0;
  int fails = 0;
  int accepted = 0;

  mips_fetch #(.MEMSIZE(MSIZE), .START_ADDR(START)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .mem_addr(mem_addr), .mem_enable(mem_enable),
    .mem_rw(mem_rw), .mem_access_size(mem_access_size), .mem_dout(mem_dout),
    .mem_busy(mem_busy), .insn(insn), .insn_pc(insn_pc), .insn_valid(insn_valid),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] widx(logic [31:0] a);
    return 8'((a - START) >> 2);
  endfunction

  function automatic logic in_win(logic [31:0] a);
    return (a >= START) && (a <= LAST);
  endfunction

  // Expected presentation order after a reset or redirect: every aligned word
  // from the new PC up to the end of the window.
  function automatic void restart(logic [31:0] target);
    logic [31:0] a;
    a = {target[31:2], 2'b00};
    exp_q.delete();
    while (in_win(a)) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endfunction

  // Memory with one-cycle read latency.
  initial mem_dout = 32'd0;
  always @(posedge clk)
    if (mem_enable && !mem_busy) mem_dout <= mem[widx(mem_addr)];

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %08h, required %08h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs change just after posedge, so at negedge they show what the
  // next edge will see; an accepted word must be the head of the expected stream.
  always @(negedge clk) begin
    if (!reset && !branch_taken && insn_valid && !stall) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_extra: got word at %08h, required none", insn_pc);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_pc", insn_pc, sb_e);
        check("sb_insn", insn, mem[widx(sb_e)]);
        accepted++;
      end
    end
    if (mem_enable) check("en_in_window", 32'(in_win(mem_addr)), 32'd1);
    check("mem_rw_size", {29'd0, mem_rw, mem_access_size}, 32'd0);
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0; mem_busy = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222; mem[2] = 32'h3333_3333;
    restart(START);
    repeat (2) step();
    check("rst_valid", 32'(insn_valid), 32'd0);
    check("rst_insn", insn, 32'd0);
    check("rst_insn_pc", insn_pc, 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_enable", 32'(mem_enable), 32'd0);
    check("rst_addr", mem_addr, START);

    // Free run
    reset = 1'b0; #1;
    check("free_en0", 32'(mem_enable), 32'd1);
    check("free_addr0", mem_addr, START);
    step();
    check("free_addr1", mem_addr, START + 4);
    check("free_valid_e1", 32'(insn_valid), 32'd0);
    step();
    check("free_valid_e2", 32'(insn_valid), 32'd1);
    check("free_insn0", insn, 32'h1111_1111);
    check("free_pc0", insn_pc, START);
    check("free_addr2", mem_addr, START + 8);

    // Stall with skid
    stall = 1'b1; #1;
    check("stall_en", 32'(mem_enable), 32'd0);
    repeat (3) begin
      step();
      check("stall_hold", insn, 32'h1111_1111);
      check("stall_en_hold", 32'(mem_enable), 32'd0);
    end
    stall = 1'b0;
    step();
    check("skid_drain_insn", insn, 32'h2222_2222);
    check("skid_drain_pc", insn_pc, START + 4);
    step();

    // Branch squash: the read of 0x80020008 is in flight now
    check("pre_branch_addr", mem_addr, START + 12);
    branch_taken = 1'b1; branch_target = 32'h8002_0103; restart(branch_target); #1;
    check("branch_en", 32'(mem_enable), 32'd0);
    step();
    branch_taken = 1'b0;
    check("branch_valid", 32'(insn_valid), 32'd0);
    check("branch_addr", mem_addr, 32'h8002_0100);
    step(); step();
    check("branch_first_pc", insn_pc, 32'h8002_0100);

    // Busy
    mem_busy = 1'b1; #1;
    check("busy_en", 32'(mem_enable), 32'd0);
    check("busy_addr", mem_addr, 32'h8002_0108);
    step();
    check("busy_deliver", insn_pc, 32'h8002_0104);
    check("busy_addr_hold", mem_addr, 32'h8002_0108);
    step();
    mem_busy = 1'b0; #1;
    check("busy_resume_en", 32'(mem_enable), 32'd1);
    check("busy_resume_addr", mem_addr, 32'h8002_0108);
    repeat (4) step();

    // Window fault
    branch_taken = 1'b1; branch_target = LAST; restart(LAST);
    step();
    branch_taken = 1'b0;
    step();
    check("fault_pc", mem_addr, START + MSIZE);
    step();
    check("fault_last_pc", insn_pc, LAST);
    check("fault_set", 32'(fetch_fault), 32'd1);
    check("fault_en", 32'(mem_enable), 32'd0);
    step();
    check("fault_last_taken", 32'(exp_q.size()), 32'd0);
    branch_taken = 1'b1; branch_target = START; restart(START);
    step();
    branch_taken = 1'b0;
    repeat (3) step();
    check("fault_sticky", 32'(fetch_fault), 32'd1);
    check("fault_sticky_en", 32'(mem_enable), 32'd0);
    check("fault_branch_addr", mem_addr, START);

    // Reset with skid full
    reset = 1'b1; restart(START);
    step();
    reset = 1'b0;
    repeat (2) step();
    stall = 1'b1;
    step();
    reset = 1'b1; restart(START);
    step();
    check("midrst_valid", 32'(insn_valid), 32'd0);
    check("midrst_addr", mem_addr, START);
    check("midrst_fault", 32'(fetch_fault), 32'd0);
    reset = 1'b0; stall = 1'b0;
    step(); step();
    check("midrst_first", insn, 32'h1111_1111);
    check("midrst_first_pc", insn_pc, START);
    step();
    check("midrst_second_pc", insn_pc, START + 4);

    // Reset with a read in flight
    reset = 1'b1; restart(START);
    step();
    check("inflight_rst_valid", 32'(insn_valid), 32'd0);
    reset = 1'b0;
    step();
    check("no_stale", 32'(insn_valid), 32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 999);
      reset = 1'b0; branch_taken = 1'b0;
      if (r < 5 || (fetch_fault && r < 60)) begin
        reset = 1'b1; restart(START);
      end else if (r < 35) begin
        branch_taken = 1'b1;
        if ($urandom_range(0, 9) == 0)
          branch_target = ($urandom_range(0, 1) == 0) ? START - 32'($urandom_range(1, 64))
                                                      : START + MSIZE + 32'($urandom_range(0, 64));
        else
          branch_target = START + 32'($urandom_range(0, MSIZE - 1));
        restart(branch_target);
      end
      stall    = ($urandom_range(0, 9) < 3);
      mem_busy = ($urandom_range(0, 9) < 2);
      step();
    end
    reset = 1'b1; restart(START);
    step();
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
    repeat (12) step();
    check("drain_pc", insn_pc, START + 40);
    check("throughput", 32'(accepted > 300), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
